// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector.
// Widths of the MAC partial sum, bias and activation, the MAC channel-phase
// encoding (must match the upstream MAC unit), and the bias/ReLU/shift/clamp
// helper used at capture.
package psum_collector_pkg;

  localparam int unsigned PSUM_W = 20;
  localparam int unsigned ACT_W  = 8;
  localparam int unsigned BIAS_W = 16;
  // One extra bit so psum + bias cannot overflow.
  localparam int unsigned SUM_W  = PSUM_W + 1;

  typedef enum logic [1:0] {
    PH_CH0 = 2'd0,
    PH_CH1 = 2'd1,
    PH_CH2 = 2'd2
  } phase_e;

  // Negative -> 0, otherwise logical shift right and saturate to ACT_W bits.
  function automatic logic [ACT_W-1:0] relu_shift_sat(
    input logic [SUM_W-1:0] sum,
    input int unsigned      shift
  );
    logic [SUM_W-1:0] shifted;
    shifted = sum >> shift;
    if (sum[SUM_W-1]) begin
      return '0;
    end else if (shifted > SUM_W'((1 << ACT_W) - 1)) begin
      return '1;
    end else begin
      return shifted[ACT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/psum_collector_act.sv
// act_fifo: synchronous FIFO holding finished activations.
// Ports: clk, rst_n (async active-low); i_push/i_wdata write side;
// i_pop read side (ignored when empty); o_head registered head value that
// holds its last value when the FIFO drains; o_full, o_empty, o_count status.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module act_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic [CNT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop        = i_pop & ~r_empty;
  assign w_push       = i_push & (~r_full | w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Head after this edge: next stored entry on a pop, the incoming word when
  // the FIFO is (or becomes) otherwise empty, else unchanged.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_count > CNT_W'(1)) begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_head_nxt = i_wdata;
      end
    end else if (r_empty && w_push) begin
      w_head_nxt = i_wdata;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_head  <= w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/psum_collector.sv
// psum_collector: captures the 3-channel partial sum at the end of each MAC
// channel rotation, applies bias + ReLU + shift + clamp, and queues the 8-bit
// activation in act_fifo.
// Ports: clk, rst_n (async active-low); en (MAC stage enable); psum_in, bias
// (signed); clr_ovf (sticky-flag clear); out_data/out_valid/out_ready
// (activation stream); ovf (capture dropped on full FIFO); frame_done (pulse
// on the NPIX-th accepted push).
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned SHIFT = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NPIX  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic [BIAS_W-1:0] bias,
  input  logic              clr_ovf,
  output logic [ACT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ovf,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PIX_W = $clog2(NPIX + 1);

  phase_e           r_phase;
  logic             r_primed;
  logic [ACT_W-1:0] r_s1_data;
  logic             r_s1_valid;
  logic             r_ovf;
  logic             r_frame_done;
  logic [PIX_W-1:0] r_pix_cnt;

  logic             w_capture;
  logic [SUM_W-1:0] w_sum;
  logic [ACT_W-1:0] w_act;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic             w_unused;

  // Phase 0 with primed set means psum_in holds a finished 3-channel sum.
  assign w_capture = en & (r_phase == PH_CH0) & r_primed;
  assign w_sum     = {psum_in[PSUM_W-1], psum_in}
                   + {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign w_act     = relu_shift_sat(w_sum, SHIFT);

  assign w_pop    = out_ready & ~w_empty;
  assign w_accept = r_s1_valid & (~w_full | w_pop);
  assign w_drop   = r_s1_valid & w_full & ~w_pop;
  assign w_unused = ^w_count;

  // Channel phase tracker, mirrors the MAC unit's rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_CH0;
      r_primed <= 1'b0;
    end else if (en) begin
      case (r_phase)
        PH_CH0:  r_phase <= PH_CH1;
        PH_CH1:  r_phase <= PH_CH2;
        PH_CH2: begin
          r_phase  <= PH_CH0;
          r_primed <= 1'b1;
        end
        default: r_phase <= PH_CH0;
      endcase
    end
  end

  // Stage-1 register between capture and FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_capture;
      if (w_capture) r_s1_data <= w_act;
    end
  end

  // Sticky overflow; a drop on the clear edge keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  // Pixel counter and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (r_pix_cnt == PIX_W'(NPIX - 1)) begin
          r_pix_cnt    <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
      end
    end
  end

  act_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ACT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_s1_valid),
    .i_wdata (r_s1_data),
    .i_pop   (out_ready),
    .o_head  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid  = ~w_empty;
  assign ovf        = r_ovf;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector (SHIFT=4, DEPTH=4, NPIX=16).
module tb_psum_collector;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [19:0] psum_in;
  logic [15:0] bias;
  logic        clr_ovf;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;
  logic        frame_done;

  psum_collector #(.SHIFT(4), .DEPTH(4), .NPIX(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .psum_in    (psum_in),
    .bias       (bias),
    .clr_ovf    (clr_ovf),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .frame_done (frame_done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_exp;
  int         fd_cnt = 0;
  int         fd_base;
  int         tb_ph = 0;
  bit         tb_primed = 0;
  bit [5:0]   gap_pat = 6'b101101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted output is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got %0d, none expected", out_data);
      end else begin
        m_exp = exp_q.pop_front();
        if (out_data !== m_exp) begin
          n_err++;
          $display("FAIL out_data: got %0d expected %0d", out_data, m_exp);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && frame_done) fd_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock edge; the bench tracks the MAC phase it expects.
  task automatic clk_step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      if (tb_ph == 2) tb_primed = 1'b1;
      tb_ph = (tb_ph == 2) ? 0 : tb_ph + 1;
    end
  endtask

  // Run until one capture edge; non-capture slots carry a decoy psum (-> 85).
  task automatic capture(input int ps, input int bs, input int ex,
                         input bit keep, input bit gaps);
    int guard = 0;
    int gi    = 0;
    bit done  = 1'b0;
    bit cap;
    logic e;
    while (!done && guard < 20) begin
      e  = gaps ? gap_pat[gi % 6] : 1'b1;
      gi++;
      cap = e && (tb_ph == 0) && tb_primed;
      psum_in = cap ? 20'(ps) : 20'h00550;
      bias    = 16'(bs);
      if (cap && keep) exp_q.push_back(8'(ex));
      clk_step(e);
      done = cap;
      guard++;
    end
    if (!done) chk("capture_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      clk_step(1'b0);
      guard++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_valid", int'(out_valid), 0);
  endtask

  initial begin
    int i;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int i;
    rst_n = 1'b0; en = 1'b0; psum_in = '0; bias = '0;
    clr_ovf = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst_n = 1'b1;

    // Capture alignment: 256>>4 = 16 visible after the 5th enabled edge.
    out_ready = 1'b1;
    psum_in = 20'd256;
    bias = '0;
    exp_q.push_back(8'd16);
    i = 0;
    while (!out_valid && i < 8) begin
      clk_step(1'b1);
      i++;
    end
    chk("first_valid_edge", i, 5);
    chk("first_out_data", int'(out_data), 16);

    // ReLU, shift and saturation vectors (SHIFT=4).
    capture(-100, 50, 0, 1, 0);
    capture(32'h3FFFF, 0, 255, 1, 0);
    capture(100, -36, 4, 1, 0);
    capture(4095, 1, 255, 1, 0);
    capture(4079, 0, 254, 1, 0);
    capture(-16, 32, 1, 1, 0);
    capture(524287, 32767, 255, 1, 0);
    capture(-524288, -32768, 0, 1, 0);
    capture(4000, 0, 250, 1, 0);
    wait_drain();

    // Backpressure: 4 retained, 5th dropped; drop on the clear edge keeps ovf.
    out_ready = 1'b0;
    capture(256, 0, 16, 1, 0);
    capture(512, 0, 32, 1, 0);
    capture(768, 0, 48, 1, 0);
    capture(1024, 0, 64, 1, 0);
    capture(1280, 0, 80, 0, 0);
    chk("bp_ovf_before_drop", int'(ovf), 0);
    clr_ovf = 1'b1;
    clk_step(1'b0);
    chk("bp_ovf_set_wins", int'(ovf), 1);
    clk_step(1'b0);
    clr_ovf = 1'b0;
    chk("bp_ovf_cleared", int'(ovf), 0);
    wait_drain();

    // Full FIFO with a pop on the push edge: nothing dropped.
    out_ready = 1'b0;
    capture(160, 0, 10, 1, 0);
    capture(320, 0, 20, 1, 0);
    capture(480, 0, 30, 1, 0);
    capture(640, 0, 40, 1, 0);
    capture(800, 0, 50, 1, 0);
    out_ready = 1'b1;
    clk_step(1'b0);
    chk("full_pop_ovf", int'(ovf), 0);
    wait_drain();

    // Enable gaps 1,0,1,1,0,1: captures follow the enabled edges only.
    capture(48, 0, 3, 1, 1);
    capture(800, -32, 48, 1, 1);
    capture(4000, 0, 250, 1, 1);
    wait_drain();

    // Reset with 3 FIFO entries and a stage-1 entry in flight.
    out_ready = 1'b0;
    capture(256, 0, 16, 1, 0);
    capture(512, 0, 32, 1, 0);
    capture(768, 0, 48, 1, 0);
    capture(1024, 0, 64, 1, 0);
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_ovf", int'(ovf), 0);
    chk("mid_rst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    tb_ph = 0;
    tb_primed = 1'b0;
    fd_base = fd_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      capture(k * 16, 0, k, 1, 0);
    end
    chk("frame_done_before_16", fd_cnt - fd_base, 0);
    clk_step(1'b0);
    @(negedge clk);
    #1;
    chk("frame_done_at_16", fd_cnt - fd_base, 1);
    chk("frame_done_level", int'(frame_done), 1);
    clk_step(1'b0);
    chk("frame_done_pulse_end", int'(frame_done), 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
